// File: rtl/universal_shift_reg_pkg.sv
// Shared definitions for the universal shift register: operation codes and
// the shift-counter width helper used by the top level and its word counter.
package universal_shift_reg_pkg;

    typedef enum logic [2:0] {
        USR_HOLD = 3'b000,
        USR_SHL  = 3'b001,
        USR_SHR  = 3'b010,
        USR_ROL  = 3'b011,
        USR_ROR  = 3'b100,
        USR_LOAD = 3'b101
    } usr_mode_e;

    // Counter width for a modulo-w count; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/usr_word_counter.sv
// Modulo-WIDTH counter with increment, synchronous clear and a registered
// one-cycle pulse on the cycle after the count wraps.
module usr_word_counter
    import universal_shift_reg_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    // Wrap at WIDTH-1 explicitly so non-power-of-two widths count correctly.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (inc) begin
            if (cnt == LAST) begin
                cnt  <= '0;
                wrap <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                wrap <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit hold/shift/rotate/load register with a shift-op counter that
// pulses word_done after every WIDTH shift or rotate operations.
module universal_shift_reg
    import universal_shift_reg_pkg::*;
#(
    parameter  int               WIDTH       = 8,
    parameter  logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int               CNT_W       = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [2:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             word_done
);

    logic [WIDTH-1:0] q_next;
    logic             is_shift;
    logic             is_load;

    always_comb begin
        q_next   = q;
        is_shift = 1'b0;
        is_load  = 1'b0;
        if (en) begin
            case (mode)
                USR_SHL: begin
                    q_next   = {q[WIDTH-2:0], sin_r};
                    is_shift = 1'b1;
                end
                USR_SHR: begin
                    q_next   = {sin_l, q[WIDTH-1:1]};
                    is_shift = 1'b1;
                end
                USR_ROL: begin
                    q_next   = {q[WIDTH-2:0], q[WIDTH-1]};
                    is_shift = 1'b1;
                end
                USR_ROR: begin
                    q_next   = {q[0], q[WIDTH-1:1]};
                    is_shift = 1'b1;
                end
                USR_LOAD: begin
                    q_next  = d;
                    is_load = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else if (clr) begin
            q <= RESET_VALUE;
        end else begin
            q <= q_next;
        end
    end

    // A load restarts the word; clr outranks any shift in the same cycle.
    usr_word_counter #(
        .WIDTH (WIDTH)
    ) u_word_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (clr | is_load),
        .inc   (is_shift & ~clr),
        .cnt   (shift_cnt),
        .wrap  (word_done)
    );

    assign sout_msb = q[WIDTH-1];
    assign sout_lsb = q[0];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg: an 8-bit instance (RESET_VALUE A5)
// and a 5-bit instance, driven with directed vectors and hand-computed results.
module tb_universal_shift_reg;
    import universal_shift_reg_pkg::*;

    typedef struct {
        logic [7:0] q;
        logic [2:0] cnt;
        logic       wd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       en8 = 1'b0, clr8 = 1'b0, sinr8 = 1'b0, sinl8 = 1'b0;
    logic [2:0] mode8 = 3'b000;
    logic [7:0] d8 = '0;
    logic [7:0] q8;
    logic       msb8, lsb8, wd8;
    logic [2:0] cnt8;

    logic       en5 = 1'b0, clr5 = 1'b0, sinr5 = 1'b0, sinl5 = 1'b0;
    logic [2:0] mode5 = 3'b000;
    logic [4:0] d5 = '0;
    logic [4:0] q5;
    logic       msb5, lsb5, wd5;
    logic [2:0] cnt5;

    universal_shift_reg #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
        .clk(clk), .reset(rst), .en(en8), .clr(clr8), .mode(mode8),
        .sin_r(sinr8), .sin_l(sinl8), .d(d8), .q(q8), .sout_msb(msb8),
        .sout_lsb(lsb8), .shift_cnt(cnt8), .word_done(wd8)
    );

    universal_shift_reg #(.WIDTH(5), .RESET_VALUE(5'h00)) dut5 (
        .clk(clk), .reset(rst), .en(en5), .clr(clr5), .mode(mode5),
        .sin_r(sinr5), .sin_l(sinl5), .d(d5), .q(q5), .sout_msb(msb5),
        .sout_lsb(lsb5), .shift_cnt(cnt5), .word_done(wd5)
    );

    int total = 0;
    int bad   = 0;
    exp_t sb8[$];
    exp_t sb5[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step8(input logic e, input logic c, input logic [2:0] m,
                         input logic sr, input logic sl, input logic [7:0] dd,
                         input logic [7:0] eq, input logic [2:0] ec, input logic ew);
        exp_t x;
        @(negedge clk);
        en8 = e; clr8 = c; mode8 = m; sinr8 = sr; sinl8 = sl; d8 = dd;
        x.q = eq; x.cnt = ec; x.wd = ew;
        sb8.push_back(x);
    endtask

    task automatic step5(input logic e, input logic c, input logic [2:0] m,
                         input logic sl, input logic [4:0] dd,
                         input logic [4:0] eq, input logic [2:0] ec, input logic ew);
        exp_t x;
        @(negedge clk);
        en5 = e; clr5 = c; mode5 = m; sinl5 = sl; d5 = dd;
        x.q = {3'b000, eq}; x.cnt = ec; x.wd = ew;
        sb5.push_back(x);
    endtask

    // Monitors: every clock a result is due for each pending vector.
    always begin
        exp_t x;
        @(posedge clk);
        #1;
        if (sb8.size() > 0) begin
            x = sb8.pop_front();
            check("q8", 32'(q8), 32'(x.q));
            check("cnt8", 32'(cnt8), 32'(x.cnt));
            check("word_done8", 32'(wd8), 32'(x.wd));
            check("sout_msb8", 32'(msb8), 32'(x.q[7]));
            check("sout_lsb8", 32'(lsb8), 32'(x.q[0]));
        end
    end

    always begin
        exp_t x;
        @(posedge clk);
        #1;
        if (sb5.size() > 0) begin
            x = sb5.pop_front();
            check("q5", 32'(q5), 32'(x.q));
            check("cnt5", 32'(cnt5), 32'(x.cnt));
            check("word_done5", 32'(wd5), 32'(x.wd));
            check("sout_msb5", 32'(msb5), 32'(x.q[4]));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [7:0] rol_tbl [8];

    initial begin
        rol_tbl = '{8'h4B, 8'h96, 8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2, 8'hA5};
        #12 rst = 1'b0;

        // Reset asserted mid-cycle takes effect without a clock edge.
        step8(1, 0, USR_LOAD, 0, 0, 8'h5A, 8'h5A, 3'd0, 0);
        step8(1, 0, USR_SHL,  1, 0, 8'h00, 8'hB5, 3'd1, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_q8", 32'(q8), 32'h A5);
        check("async_rst_cnt8", 32'(cnt8), 32'd0);
        check("async_rst_wd8", 32'(wd8), 32'd0);
        check("async_rst_q5", 32'(q5), 32'h00);
        #1 rst = 1'b0;

        // Load then hold with en low (mode ignored).
        step8(1, 0, USR_LOAD, 0, 0, 8'h3C, 8'h3C, 3'd0, 0);
        for (int i = 0; i < 3; i++) step8(0, 0, USR_SHL, 1, 1, 8'h00, 8'h3C, 3'd0, 0);

        // Eight shifts left with sin_r=1; word_done only after the eighth.
        step8(1, 0, USR_LOAD, 0, 0, 8'h81, 8'h81, 3'd0, 0);
        step8(1, 0, USR_SHL, 1, 0, 8'h00, 8'h03, 3'd1, 0);
        step8(1, 0, USR_SHL, 1, 0, 8'h00, 8'h07, 3'd2, 0);
        step8(1, 0, USR_SHL, 1, 0, 8'h00, 8'h0F, 3'd3, 0);
        step8(1, 0, USR_SHL, 1, 0, 8'h00, 8'h1F, 3'd4, 0);
        step8(1, 0, USR_SHL, 1, 0, 8'h00, 8'h3F, 3'd5, 0);
        step8(1, 0, USR_SHL, 1, 0, 8'h00, 8'h7F, 3'd6, 0);
        step8(1, 0, USR_SHL, 1, 0, 8'h00, 8'hFF, 3'd7, 0);
        step8(1, 0, USR_SHL, 1, 0, 8'h00, 8'hFF, 3'd0, 1);
        step8(1, 0, USR_HOLD, 1, 0, 8'h00, 8'hFF, 3'd0, 0);

        // Rotates, shift right, hold and reserved modes.
        step8(1, 0, USR_LOAD, 0, 0, 8'h81, 8'h81, 3'd0, 0);
        step8(1, 0, USR_ROR,  0, 0, 8'h00, 8'hC0, 3'd1, 0);
        step8(1, 0, USR_ROL,  0, 0, 8'h00, 8'h81, 3'd2, 0);
        step8(1, 0, USR_SHR,  0, 0, 8'h00, 8'h40, 3'd3, 0);
        step8(1, 0, USR_HOLD, 1, 1, 8'hFF, 8'h40, 3'd3, 0);
        step8(1, 0, 3'b110,   1, 1, 8'hFF, 8'h40, 3'd3, 0);
        step8(1, 0, USR_SHL,  0, 0, 8'h00, 8'h80, 3'd4, 0);

        // clr outranks en/LOAD; clr at count 7 suppresses word_done.
        step8(1, 1, USR_LOAD, 0, 0, 8'hFF, 8'hA5, 3'd0, 0);
        step8(1, 0, USR_SHL, 0, 0, 8'h00, 8'h4A, 3'd1, 0);
        step8(1, 0, USR_SHL, 0, 0, 8'h00, 8'h94, 3'd2, 0);
        step8(1, 0, USR_SHL, 0, 0, 8'h00, 8'h28, 3'd3, 0);
        step8(1, 0, USR_SHL, 0, 0, 8'h00, 8'h50, 3'd4, 0);
        step8(1, 0, USR_SHL, 0, 0, 8'h00, 8'hA0, 3'd5, 0);
        step8(1, 0, USR_SHL, 0, 0, 8'h00, 8'h40, 3'd6, 0);
        step8(1, 0, USR_SHL, 0, 0, 8'h00, 8'h80, 3'd7, 0);
        step8(1, 1, USR_SHL, 1, 0, 8'h00, 8'hA5, 3'd0, 0);
        step8(0, 0, USR_HOLD, 0, 0, 8'h00, 8'hA5, 3'd0, 0);

        // Back-to-back words of rotates: word_done every eighth op, no gap.
        for (int i = 0; i < 16; i++)
            step8(1, 0, USR_ROL, 0, 0, 8'h00, rol_tbl[i % 8], 3'((i + 1) % 8), (i == 7) || (i == 15));

        // A load discards a partial word.
        step8(1, 0, USR_SHL,  0, 0, 8'h00, 8'h4A, 3'd1, 0);
        step8(1, 0, USR_SHL,  0, 0, 8'h00, 8'h94, 3'd2, 0);
        step8(1, 0, USR_LOAD, 0, 0, 8'h00, 8'h00, 3'd0, 0);
        step8(0, 0, USR_HOLD, 0, 0, 8'h00, 8'h00, 3'd0, 0);

        // Width 5: wrap at 4, word_done after shifts 5 and 10.
        step5(1, 0, USR_LOAD, 0, 5'h16, 5'h16, 3'd0, 0);
        step5(1, 0, USR_SHR, 1, 5'h00, 5'h1B, 3'd1, 0);
        step5(1, 0, USR_SHR, 1, 5'h00, 5'h1D, 3'd2, 0);
        step5(1, 0, USR_SHR, 1, 5'h00, 5'h1E, 3'd3, 0);
        step5(1, 0, USR_SHR, 1, 5'h00, 5'h1F, 3'd4, 0);
        step5(1, 0, USR_SHR, 1, 5'h00, 5'h1F, 3'd0, 1);
        step5(1, 0, USR_SHR, 0, 5'h00, 5'h0F, 3'd1, 0);
        step5(1, 0, USR_SHR, 0, 5'h00, 5'h07, 3'd2, 0);
        step5(1, 0, USR_SHR, 0, 5'h00, 5'h03, 3'd3, 0);
        step5(1, 0, USR_SHR, 0, 5'h00, 5'h01, 3'd4, 0);
        step5(1, 0, USR_SHR, 0, 5'h00, 5'h00, 3'd0, 1);
        step5(1, 0, USR_SHR, 1, 5'h00, 5'h10, 3'd1, 0);
        step5(1, 0, 3'b111,  1, 5'h1F, 5'h10, 3'd1, 0);
        step5(0, 0, USR_HOLD, 0, 5'h00, 5'h10, 3'd1, 0);

        for (int i = 0; i < 10 && (sb8.size() > 0 || sb5.size() > 0); i++) @(posedge clk);
        #2;
        check("drain", 32'(sb8.size() + sb5.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
